// File: rtl/cpu_step_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_step_ctrl
//  Brief    : Run/step controller issuing the pipeline clock enable (cpu_en)
//             for single step, divided free run, fixed bursts and breakpoints.
//  Revision : 1.0  initial release
// ============================================================================
module cpu_step_ctrl #(
   parameter int RUN_DIV   = 50_000_000,
   parameter int BURST_LEN = 16,
   parameter int DIV_W     = 26
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        step_p,
   input  logic        run_p,
   input  logic        burst_p,
   input  logic        halt_req,
   input  logic [31:0] pc_in,
   input  logic [31:0] bp_addr,
   input  logic        bp_en,
   output logic        cpu_en,
   output logic [1:0]  mode,
   output logic        halted,
   output logic        bp_hit,
   output logic [31:0] cyc_cnt
);

   localparam int               c_REM_W   = $clog2(BURST_LEN + 1);
   localparam logic [DIV_W-1:0] c_DIV_MAX = DIV_W'(RUN_DIV - 1);
   localparam logic [c_REM_W-1:0] c_BURST = c_REM_W'(BURST_LEN);

   typedef enum logic [1:0] {
      S_HALT  = 2'b00,
      S_STEP  = 2'b01,
      S_RUN   = 2'b10,
      S_BURST = 2'b11
   } state_t;

   state_t               r_state, w_state_nxt;
   logic [DIV_W-1:0]     r_presc, w_presc_nxt, w_cnt;
   logic [c_REM_W-1:0]   r_rem, w_rem_nxt, w_rem_cur;
   logic                 r_skip, w_skip_nxt, w_skip_cur;
   logic                 r_cpu_en, w_en_nxt;
   logic                 r_bp_hit, w_bp_nxt;
   logic                 r_halted;
   logic [31:0]          r_cyc_cnt;
   logic                 w_tick, w_exit, w_burst, w_wrap;

   always_comb begin
      w_state_nxt = r_state;
      w_presc_nxt = '0;
      w_rem_nxt   = r_rem;
      w_skip_nxt  = r_skip;
      w_en_nxt    = 1'b0;
      w_bp_nxt    = 1'b0;
      w_tick      = 1'b0;
      w_exit      = 1'b0;
      w_burst     = 1'b0;
      w_wrap      = 1'b0;
      w_cnt       = r_presc;
      w_skip_cur  = r_skip;
      w_rem_cur   = r_rem;

      case (r_state)
         S_HALT: begin
            if (!halt_req) begin
               if (run_p) begin
                  w_state_nxt = S_RUN;
                  w_exit      = 1'b1;
               end else if (burst_p) begin
                  w_state_nxt = S_BURST;
                  w_exit      = 1'b1;
                  w_burst     = 1'b1;
                  w_rem_cur   = c_BURST;
                  w_rem_nxt   = c_BURST;
               end else if (step_p) begin
                  w_state_nxt = S_STEP;
                  w_en_nxt    = 1'b1;
                  w_skip_nxt  = 1'b1;
               end
            end
         end
         S_STEP: w_state_nxt = S_HALT;
         S_RUN: begin
            if (halt_req || run_p) w_state_nxt = S_HALT;
            else                   w_tick      = 1'b1;
         end
         S_BURST: begin
            w_burst = 1'b1;
            // remaining==0 means the final enable is on cpu_en right now
            if (halt_req || run_p || r_rem == '0) begin
               w_state_nxt = S_HALT;
               w_rem_nxt   = '0;
            end else begin
               w_tick = 1'b1;
            end
         end
         default: w_state_nxt = S_HALT;
      endcase

      // The exit cycle itself counts as prescaler tick 0
      if (w_exit) begin
         w_cnt      = '0;
         w_skip_cur = 1'b1;
      end

      if (w_tick || w_exit) begin
         w_wrap      = (w_cnt == c_DIV_MAX);
         w_skip_nxt  = w_skip_cur;
         w_presc_nxt = w_wrap ? '0 : w_cnt + DIV_W'(1);
         if (w_wrap) begin
            if (bp_en && (pc_in == bp_addr) && !w_skip_cur) begin
               w_state_nxt = S_HALT;
               w_bp_nxt    = 1'b1;
               w_presc_nxt = '0;
               w_rem_nxt   = '0;
            end else begin
               w_en_nxt   = 1'b1;
               w_skip_nxt = 1'b0;
               if (w_burst) w_rem_nxt = w_rem_cur - c_REM_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_HALT;
         r_presc   <= '0;
         r_rem     <= '0;
         r_skip    <= 1'b0;
         r_cpu_en  <= 1'b0;
         r_bp_hit  <= 1'b0;
         r_halted  <= 1'b1;
         r_cyc_cnt <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_presc   <= w_presc_nxt;
         r_rem     <= w_rem_nxt;
         r_skip    <= w_skip_nxt;
         r_cpu_en  <= w_en_nxt;
         r_bp_hit  <= w_bp_nxt;
         r_halted  <= (w_state_nxt == S_HALT);
         if (w_en_nxt) r_cyc_cnt <= r_cyc_cnt + 32'd1;
      end
   end

   assign cpu_en  = r_cpu_en;
   assign mode    = r_state;
   assign halted  = r_halted;
   assign bp_hit  = r_bp_hit;
   assign cyc_cnt = r_cyc_cnt;

endmodule
`default_nettype wire

// File: tb/tb_cpu_step_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cpu_step_ctrl
//  Brief    : Directed self-checking bench for cpu_step_ctrl.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_cpu_step_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        step_p, run_p, burst_p, halt_req, bp_en;
   logic [31:0] pc_in, bp_addr;
   logic        step1_p, run1_p, burst1_p;

   logic        cpu_en, halted, bp_hit;
   logic [1:0]  mode;
   logic [31:0] cyc_cnt;
   logic        cpu_en1, halted1, bp_hit1;
   logic [1:0]  mode1;
   logic [31:0] cyc_cnt1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   cpu_step_ctrl #(.RUN_DIV(4), .BURST_LEN(3), .DIV_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .step_p(step_p), .run_p(run_p), .burst_p(burst_p),
      .halt_req(halt_req), .pc_in(pc_in), .bp_addr(bp_addr), .bp_en(bp_en),
      .cpu_en(cpu_en), .mode(mode), .halted(halted), .bp_hit(bp_hit), .cyc_cnt(cyc_cnt)
   );

   cpu_step_ctrl #(.RUN_DIV(1), .BURST_LEN(3), .DIV_W(4)) dut1 (
      .clk(clk), .rst_n(rst_n), .step_p(step1_p), .run_p(run1_p), .burst_p(burst1_p),
      .halt_req(halt_req), .pc_in(pc_in), .bp_addr(bp_addr), .bp_en(bp_en),
      .cpu_en(cpu_en1), .mode(mode1), .halted(halted1), .bp_hit(bp_hit1), .cyc_cnt(cyc_cnt1)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; step_p = 0; run_p = 0; burst_p = 0; halt_req = 0; bp_en = 0;
      pc_in = 32'h0; bp_addr = 32'h0; step1_p = 0; run1_p = 0; burst1_p = 0;
      tick(); tick();
      checks++;
      if ({cpu_en, mode, halted, bp_hit, cyc_cnt} !== {1'b0, 2'b00, 1'b1, 1'b0, 32'h0}) begin
         errors++;
         $display("FAIL reset: got en=%b mode=%b halted=%b bp=%b cnt=%h, expected 0 00 1 0 0",
                  cpu_en, mode, halted, bp_hit, cyc_cnt);
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_step();
      step_p = 1; tick(); step_p = 0;
      checks++;
      if (cpu_en !== 1'b1 || mode !== 2'b01) begin
         errors++;
         $display("FAIL step_t1: got en=%b mode=%b, expected 1 01", cpu_en, mode);
      end
      tick();
      checks++;
      if (cpu_en !== 1'b0 || mode !== 2'b00 || halted !== 1'b1 || cyc_cnt !== 32'd1) begin
         errors++;
         $display("FAIL step_t2: got en=%b mode=%b halted=%b cnt=%0d, expected 0 00 1 1",
                  cpu_en, mode, halted, cyc_cnt);
      end
   endtask

   task automatic test_run();
      logic       exp_en;
      logic [1:0] exp_mode;
      run_p = 1; tick(); run_p = 0;
      for (int k = 1; k <= 13; k++) begin
         exp_en   = (k == 4) || (k == 8);
         exp_mode = (k <= 10) ? 2'b10 : 2'b00;
         checks++;
         if (cpu_en !== exp_en || mode !== exp_mode) begin
            errors++;
            $display("FAIL run_t%0d: got en=%b mode=%b, expected %b %b", k, cpu_en, mode, exp_en, exp_mode);
         end
         run_p = (k == 10);
         tick();
         run_p = 0;
      end
      checks++;
      if (cyc_cnt !== 32'd3) begin
         errors++;
         $display("FAIL run_cnt: got %0d expected 3", cyc_cnt);
      end
   endtask

   task automatic test_burst();
      logic       exp_en;
      logic [1:0] exp_mode;
      burst1_p = 1; tick(); burst1_p = 0;
      for (int k = 1; k <= 5; k++) begin
         exp_en   = (k <= 3);
         exp_mode = (k <= 3) ? 2'b11 : 2'b00;
         checks++;
         if (cpu_en1 !== exp_en || mode1 !== exp_mode) begin
            errors++;
            $display("FAIL burst_t%0d: got en=%b mode=%b, expected %b %b", k, cpu_en1, mode1, exp_en, exp_mode);
         end
         tick();
      end
      checks++;
      if (cyc_cnt1 !== 32'd3 || halted1 !== 1'b1) begin
         errors++;
         $display("FAIL burst_cnt: got cnt=%0d halted=%b, expected 3 1", cyc_cnt1, halted1);
      end
   endtask

   task automatic test_breakpoint();
      logic       exp_en, exp_bp;
      logic [1:0] exp_mode;
      bp_en = 1; bp_addr = 32'h40; pc_in = 32'h0;
      for (int pass = 0; pass < 2; pass++) begin
         run_p = 1; tick(); run_p = 0;
         for (int k = 1; k <= 10; k++) begin
            if (k >= 5) pc_in = 32'h40;
            exp_en   = (k == 4);
            exp_bp   = (k == 8);
            exp_mode = (k <= 7) ? 2'b10 : 2'b00;
            checks++;
            if (cpu_en !== exp_en || bp_hit !== exp_bp || mode !== exp_mode) begin
               errors++;
               $display("FAIL bp%0d_t%0d: got en=%b bp=%b mode=%b, expected %b %b %b",
                        pass, k, cpu_en, bp_hit, mode, exp_en, exp_bp, exp_mode);
            end
            tick();
         end
      end
      checks++;
      if (cyc_cnt !== 32'd5) begin
         errors++;
         $display("FAIL bp_cnt: got %0d expected 5", cyc_cnt);
      end
      bp_en = 0; pc_in = 32'h0;
   endtask

   task automatic test_priority_halt();
      run_p = 1; burst_p = 1; step_p = 1; tick();
      run_p = 0; burst_p = 0; step_p = 0;
      checks++;
      if (mode !== 2'b10 || cpu_en !== 1'b0) begin
         errors++;
         $display("FAIL priority: got mode=%b en=%b, expected 10 0", mode, cpu_en);
      end
      halt_req = 1; tick();
      checks++;
      if (mode !== 2'b00 || halted !== 1'b1) begin
         errors++;
         $display("FAIL halt_req: got mode=%b halted=%b, expected 00 1", mode, halted);
      end
      step_p = 1; tick(); step_p = 0;
      run_p = 1; tick(); run_p = 0;
      for (int k = 0; k < 6; k++) begin
         checks++;
         if (mode !== 2'b00 || cpu_en !== 1'b0) begin
            errors++;
            $display("FAIL halt_hold_%0d: got mode=%b en=%b, expected 00 0", k, mode, cpu_en);
         end
         tick();
      end
      halt_req = 0; tick();
   endtask

   task automatic test_wrap();
      force dut.r_cyc_cnt = 32'hFFFF_FFFF;
      #1;
      release dut.r_cyc_cnt;
      step_p = 1; tick(); step_p = 0;
      tick();
      checks++;
      if (cyc_cnt !== 32'h0 || mode !== 2'b00) begin
         errors++;
         $display("FAIL cnt_wrap: got cnt=%h mode=%b, expected 00000000 00", cyc_cnt, mode);
      end
   endtask

   task automatic test_reset_mid_run();
      run_p = 1; tick(); run_p = 0;
      tick(); tick();
      rst_n = 1'b0;
      #1;
      checks++;
      if ({cpu_en, mode, halted, bp_hit, cyc_cnt} !== {1'b0, 2'b00, 1'b1, 1'b0, 32'h0}) begin
         errors++;
         $display("FAIL reset_mid_run: got en=%b mode=%b halted=%b bp=%b cnt=%h, expected 0 00 1 0 0",
                  cpu_en, mode, halted, bp_hit, cyc_cnt);
      end
      tick();
      rst_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         checks++;
         if (cpu_en !== 1'b0 || mode !== 2'b00 || cpu_en1 !== 1'b0 || cyc_cnt1 !== 32'h0) begin
            errors++;
            $display("FAIL post_reset_%0d: got en=%b mode=%b en1=%b cnt1=%0d, expected 0 00 0 0",
                     k, cpu_en, mode, cpu_en1, cyc_cnt1);
         end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_step();
      test_run();
      test_burst();
      test_breakpoint();
      test_priority_halt();
      test_wrap();
      test_reset_mid_run();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, expected finish before 200000 ns");
      $fatal(1);
   end

endmodule
`default_nettype wire
